lcd_ddram_reader: RTL and testbench
===================================

// Module: lcd_ddram_reader
// PURPOSE
// - Read-back side of the character-LCD (HD44780-type, 8-bit bus) interface: reads the 32 displayed chars
//   (DDRAM 0x00-0x0F, 0x40-0x4F) and streams them out for on-chip screen checking / debug capture.
// - Sits beside the LCD write controllers and drives the same LCD pins while busy; an external mux selects the owner.
// PARAMETERS
// - PHASE_CYCLES  500  clk_1MHz cycles per bus phase minus one (each phase lasts PHASE_CYCLES+1 clocks)
// - BF_TIMEOUT    255  max busy-flag polls per char before abort (used only with LCD_BUSY_POLL_EN)
// PORTS
// - clk_1MHz      in   1  1 MHz system clock
// - rst           in   1  asynchronous, active-high reset
// - start         in   1  one-cycle pulse: begin full-screen read; ignored while busy=1
// - busy          out  1  high from the clock after start is accepted until done
// - done          out  1  one-cycle pulse when the scan ends (normal or aborted)
// - timeout_err   out  1  sticky; set on busy-flag timeout, cleared by next accepted start
// - char_valid    out  1  one-cycle strobe: char_data/char_idx valid
// - char_data     out  8  DDRAM byte read
// - char_idx      out  5  0-15 = line1 col, 16-31 = line2 col
// - lcd_rs        out  1  register select (0 cmd/BF, 1 data)
// - lcd_rw        out  1  1 read, 0 write
// - lcd_en        out  1  LCD enable strobe
// - lcd_data_out  out  8  bus value when driving
// - lcd_data_oe   out  1  1 = drive lcd_data_out onto the pad; 0 = release (tri-state)
// - lcd_data_in   in   8  pad input sample
// BEHAVIOUR
// - Reset (async, any state): all outputs 0, FSM -> IDLE, idx=0, phase counter=0; lcd_en drops immediately.
// - Phase timing: counter 0..PHASE_CYCLES, then advance to the next state with counter cleared.
// - FSM per char idx (addr = idx<16 ? idx : 0x40+idx-16):
//   - IDLE: start=1 -> BF_EN (with macro) / SETA_EN (without); idx=0, busy=1, timeout_err=0.
//   - BF_EN: rs=0 rw=1 oe=0 en=1; lcd_data_in sampled on the phase's last clock.
//   - BF_LO: en=0; at phase end: bit7=0 -> SETA_EN; bit7=1 -> poll again (BF_EN).
//     - After BF_TIMEOUT consecutive busy polls: timeout_err=1, done pulse -> IDLE.
//   - SETA_EN: rs=0 rw=0 oe=1 data_out=8'h80|addr en=1. SETA_LO: en=0 (oe, data held).
//   - RD_EN: rs=1 rw=1 oe=0 en=1; data sampled on last clock into char_data.
//   - RD_LO: en=0; char_valid=1 on its first clock with char_idx=idx.
//     - At phase end: idx<31 -> idx+1, back to first per-char state; idx=31 -> done pulse, busy=0, IDLE.
// - Bus safety: rw and rs change only while en=0; oe=0 in every rw=1 phase and in IDLE.
//   - oe falls on the same clock rw rises.
// - Latency: per char 6*(PHASE_CYCLES+1) clocks with macro (BF clear), 4*(PHASE_CYCLES+1) without.
//   - Each busy poll adds 2*(PHASE_CYCLES+1).
// - start coincident with rst: rst wins. start during busy: no effect, no error.
// - Reset mid-scan: no done/char_valid emitted; a fresh start rescans from idx 0.
// CONFIGURATION
// - LCD_BUSY_POLL_EN defined: BF_EN/BF_LO states, BF_TIMEOUT and timeout_err active.
// - Undefined: no BF states; SETA_EN follows IDLE/RD_LO directly (fixed-delay pacing only).
//   - timeout_err tied 0.
// TESTING
// - PHASE_CYCLES=4, LCD model preloaded "BunnyGame JUMP:1"/" START:* RESET:#", start -> 32 char_valid.
//   - idx0=8'h42, idx15=8'h31, idx16=8'h20, idx31=8'h23; one done pulse; busy low after.
// - Same, check bus: SETA_EN for idx17 drives 8'hC1 with oe=1, rw=0.
//   - No cycle with oe=1 and rw=1; rs/rw stable while en=1.
// - Macro on, PHASE_CYCLES=4, model returns BF=1 for 3 polls then 0.
//   - First char_valid at 11*5 = 55 clocks after leaving IDLE; timeout_err=0.
// - Macro on, BF_TIMEOUT=3, BF stuck 1 -> after 3 polls timeout_err=1.
//   - done pulses, no char_valid, busy=0.
// - Assert rst during RD_EN of idx 9 -> same clock en=0, all outputs 0.
//   - Fresh start -> char_idx restarts at 0.
// - Second start pulse while busy -> ignored: exactly 32 strobes and one done.

Source files
------------

// File: rtl/lcd_ddram_reader.sv
// HD44780 DDRAM read-back: scans the 32 visible characters and streams them out as char_valid strobes.
// Optional busy-flag polling before each character is enabled by defining LCD_BUSY_POLL_EN.
`timescale 1ns/1ps
module lcd_ddram_reader #(
    parameter int unsigned PHASE_CYCLES = 500,
    parameter int unsigned BF_TIMEOUT   = 255
) (
    input  logic       clk_1MHz,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       timeout_err,
    output logic       char_valid,
    output logic [7:0] char_data,
    output logic [4:0] char_idx,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    input  logic [7:0] lcd_data_in
);

    localparam int unsigned  CW      = (PHASE_CYCLES < 1) ? 1 : $clog2(PHASE_CYCLES + 1);
    localparam logic [CW-1:0] PH_LAST = CW'(PHASE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BF_EN,
        S_BF_LO,
        S_SETA_EN,
        S_SETA_LO,
        S_RD_EN,
        S_RD_LO
    } state_t;

`ifdef LCD_BUSY_POLL_EN
    localparam state_t CHAR_FIRST = S_BF_EN;
`else
    localparam state_t CHAR_FIRST = S_SETA_EN;
`endif

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [4:0]    idx;
    logic [7:0]    rd_data;
    logic          done_r;
    logic          phase_end;
    logic          last_char;
    logic          scan_end;
    logic          bf_abort;

    assign phase_end = (cnt == PH_LAST);
    assign last_char = (idx == 5'd31);

`ifdef LCD_BUSY_POLL_EN
    localparam int unsigned PW = (BF_TIMEOUT < 2) ? 1 : $clog2(BF_TIMEOUT);

    logic          bf_r;
    logic [PW-1:0] poll_cnt;
    logic          to_r;

    // poll_cnt holds busy polls already seen for this char; the BF_TIMEOUT-th busy result aborts
    assign bf_abort = (state == S_BF_LO) && phase_end && bf_r &&
                      (poll_cnt == PW'(BF_TIMEOUT - 1));

    always_ff @(posedge clk_1MHz or posedge rst) begin
        if (rst) begin
            bf_r     <= 1'b0;
            poll_cnt <= '0;
            to_r     <= 1'b0;
        end else begin
            if (state == S_BF_EN && phase_end)
                bf_r <= lcd_data_in[7];

            if (state == S_BF_LO && phase_end)
                poll_cnt <= bf_r ? poll_cnt + PW'(1) : '0;
            else if (state == S_IDLE)
                poll_cnt <= '0;

            if (state == S_IDLE && start)
                to_r <= 1'b0;
            else if (bf_abort)
                to_r <= 1'b1;
        end
    end

    assign timeout_err = to_r;
`else
    assign bf_abort    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign scan_end = (state == S_RD_LO && phase_end && last_char) || bf_abort;

    always_ff @(posedge clk_1MHz or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            idx     <= '0;
            rd_data <= '0;
            done_r  <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= (state == S_IDLE || phase_end) ? '0 : cnt + CW'(1);
            done_r <= scan_end;

            if (state == S_IDLE && start)
                idx <= '0;
            else if (state == S_RD_LO && phase_end && !last_char)
                idx <= idx + 5'd1;

            if (state == S_RD_EN && phase_end)
                rd_data <= lcd_data_in;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nx = CHAR_FIRST;
            end
`ifdef LCD_BUSY_POLL_EN
            S_BF_EN: begin
                if (phase_end)
                    state_nx = S_BF_LO;
            end
            S_BF_LO: begin
                if (phase_end) begin
                    if (!bf_r)
                        state_nx = S_SETA_EN;
                    else if (bf_abort)
                        state_nx = S_IDLE;
                    else
                        state_nx = S_BF_EN;
                end
            end
`endif
            S_SETA_EN: begin
                if (phase_end)
                    state_nx = S_SETA_LO;
            end
            S_SETA_LO: begin
                if (phase_end)
                    state_nx = S_RD_EN;
            end
            S_RD_EN: begin
                if (phase_end)
                    state_nx = S_RD_LO;
            end
            S_RD_LO: begin
                if (phase_end)
                    state_nx = last_char ? S_IDLE : CHAR_FIRST;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Each LO phase repeats its EN phase's rs/rw/oe so those lines only move while en is low
    always_comb begin
        lcd_rs       = 1'b0;
        lcd_rw       = 1'b0;
        lcd_en       = 1'b0;
        lcd_data_oe  = 1'b0;
        lcd_data_out = '0;
        case (state)
            S_BF_EN, S_BF_LO: begin
                lcd_rw = 1'b1;
                lcd_en = (state == S_BF_EN);
            end
            S_SETA_EN, S_SETA_LO: begin
                lcd_data_oe  = 1'b1;
                lcd_data_out = {1'b1, idx[4], 2'b00, idx[3:0]};
                lcd_en       = (state == S_SETA_EN);
            end
            S_RD_EN, S_RD_LO: begin
                lcd_rs = 1'b1;
                lcd_rw = 1'b1;
                lcd_en = (state == S_RD_EN);
            end
            default: ;
        endcase
    end

    assign busy       = (state != S_IDLE);
    assign done       = done_r;
    assign char_valid = (state == S_RD_LO) && (cnt == '0);
    assign char_data  = rd_data;
    assign char_idx   = idx;

endmodule

// File: tb/tb_lcd_ddram_reader.sv
// Bench for lcd_ddram_reader: LCD bus model with preloaded DDRAM, scoreboard on the char stream,
// table of spot checks, and hand sequences for reset, double start and (with LCD_BUSY_POLL_EN) busy polling.
`timescale 1ns/1ps
module tb_lcd_ddram_reader;

    localparam int unsigned PH = 4;
`ifdef LCD_BUSY_POLL_EN
    localparam int FIRST_LAT = 5 * (PH + 1);
    localparam int PER_CHAR  = 6 * (PH + 1);
`else
    localparam int FIRST_LAT = 3 * (PH + 1);
    localparam int PER_CHAR  = 4 * (PH + 1);
`endif

    logic       clk_1MHz = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, timeout_err, char_valid;
    logic [7:0] char_data;
    logic [4:0] char_idx;
    logic       lcd_rs, lcd_rw, lcd_en, lcd_data_oe;
    logic [7:0] lcd_data_out;
    logic [7:0] lcd_data_in;

    always #500 clk_1MHz = ~clk_1MHz;

    lcd_ddram_reader #(.PHASE_CYCLES(PH), .BF_TIMEOUT(255)) dut (
        .clk_1MHz     (clk_1MHz),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .timeout_err  (timeout_err),
        .char_valid   (char_valid),
        .char_data    (char_data),
        .char_idx     (char_idx),
        .lcd_rs       (lcd_rs),
        .lcd_rw       (lcd_rw),
        .lcd_en       (lcd_en),
        .lcd_data_out (lcd_data_out),
        .lcd_data_oe  (lcd_data_oe),
        .lcd_data_in  (lcd_data_in)
    );

    // LCD model: address latched on falling en of a command write, BF reported while polls remain
    logic [7:0] mem [0:127];
    logic [6:0] addr_reg = '0;
    int         bf_polls_left = 0;
    string      l1 = "BunnyGame JUMP:1";
    string      l2 = " START:* RESET:#";

    always @(negedge lcd_en) begin
        if (!lcd_rw && !lcd_rs)
            addr_reg = lcd_data_out[6:0];
        else if (lcd_rw && !lcd_rs && bf_polls_left > 0)
            bf_polls_left = bf_polls_left - 1;
    end

    assign lcd_data_in = (lcd_rs && lcd_rw) ? mem[addr_reg] :
                         lcd_rw ? {(bf_polls_left > 0), addr_reg} : 8'h00;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act === exp)
            passed = passed + 1;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] exp_byte(input int i);
        return (i < 16) ? l1[i] : l2[i - 16];
    endfunction

    typedef struct packed {
        logic [4:0] idx;
        logic [7:0] data;
    } sb_t;
    sb_t sb[$];

    int         cyc = 0;
    int         n_valid = 0, n_done = 0, bus_viol = 0;
    int         first_t = -1, second_t = -1, t_rise = -1;
    logic       prev_en = 1'b0, prev_rs = 1'b0, prev_rw = 1'b0, prev_busy = 1'b0;
    logic [7:0] got_char [32];
    logic [7:0] seta_cmd [32];

    always @(negedge clk_1MHz) begin
        sb_t e;
        cyc = cyc + 1;
        if (lcd_data_oe && lcd_rw)
            bus_viol = bus_viol + 1;
        if (lcd_en && prev_en && (lcd_rs != prev_rs || lcd_rw != prev_rw))
            bus_viol = bus_viol + 1;
        prev_en = lcd_en;
        prev_rs = lcd_rs;
        prev_rw = lcd_rw;
        if (busy && !prev_busy)
            t_rise = cyc;
        prev_busy = busy;
        if (lcd_en && lcd_data_oe && !lcd_rw && !lcd_rs && n_valid < 32)
            seta_cmd[n_valid] = lcd_data_out;
        if (char_valid) begin
            if (first_t < 0)
                first_t = cyc;
            else if (second_t < 0)
                second_t = cyc;
            got_char[char_idx] = char_data;
            n_valid = n_valid + 1;
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("char_stream", 32'({char_idx, char_data}), 32'({e.idx, e.data}));
            end
        end
        if (done)
            n_done = n_done + 1;
    end

`ifdef LCD_BUSY_POLL_EN
    logic       start_to = 1'b0;
    logic       busy_to, done_to, timeout_err_to, char_valid_to;
    logic [7:0] char_data_to, lcd_data_out_to;
    logic [4:0] char_idx_to;
    logic       lcd_rs_to, lcd_rw_to, lcd_en_to, lcd_data_oe_to;
    logic [7:0] lcd_data_in_to;
    int         n_valid_to = 0, n_done_to = 0;

    assign lcd_data_in_to = 8'h80;

    lcd_ddram_reader #(.PHASE_CYCLES(PH), .BF_TIMEOUT(3)) dut_to (
        .clk_1MHz     (clk_1MHz),
        .rst          (rst),
        .start        (start_to),
        .busy         (busy_to),
        .done         (done_to),
        .timeout_err  (timeout_err_to),
        .char_valid   (char_valid_to),
        .char_data    (char_data_to),
        .char_idx     (char_idx_to),
        .lcd_rs       (lcd_rs_to),
        .lcd_rw       (lcd_rw_to),
        .lcd_en       (lcd_en_to),
        .lcd_data_out (lcd_data_out_to),
        .lcd_data_oe  (lcd_data_oe_to),
        .lcd_data_in  (lcd_data_in_to)
    );

    always @(negedge clk_1MHz) begin
        if (char_valid_to) n_valid_to = n_valid_to + 1;
        if (done_to)       n_done_to  = n_done_to + 1;
    end
`endif

    task automatic pulse_start();
        @(negedge clk_1MHz);
        start = 1'b1;
        @(negedge clk_1MHz);
        start = 1'b0;
    endtask

    task automatic prime_scan();
        n_valid  = 0;
        n_done   = 0;
        first_t  = -1;
        second_t = -1;
        t_rise   = -1;
        sb.delete();
        for (int i = 0; i < 32; i++) begin
            sb.push_back('{idx: 5'(i), data: exp_byte(i)});
            got_char[i] = '0;
            seta_cmd[i] = '0;
        end
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while (n_done == 0 && c < budget) begin
            @(posedge clk_1MHz);
            c = c + 1;
        end
        @(negedge clk_1MHz);
        #1;
        check("done_within_budget", 32'(n_done > 0), 32'd1);
    endtask

    task automatic run_scan(input int exp_first, input bit double_start);
        prime_scan();
        pulse_start();
        if (double_start) begin
            repeat (100) @(negedge clk_1MHz);
            pulse_start();
        end
        wait_done(3000);
        repeat (5) @(negedge clk_1MHz);
        #1;
        check("valid_count", n_valid, 32);
        check("done_count", n_done, 1);
        check("busy_after_done", 32'(busy), 32'd0);
        check("sb_empty", sb.size(), 0);
        check("first_valid_latency", first_t - t_rise, exp_first);
        check("char_spacing", second_t - first_t, PER_CHAR);
        check("timeout_err_clear", 32'(timeout_err), 32'd0);
    endtask

    typedef struct {
        int         idx;
        logic [7:0] exp_char;
        logic [7:0] exp_cmd;
    } vec_t;
    vec_t vecs [6];

    initial begin
        int  nv, nd;
        bit  found;

        for (int i = 0; i < 128; i++) mem[i] = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            mem[i]      = l1[i];
            mem[64 + i] = l2[i];
        end
        vecs[0] = '{idx: 0,  exp_char: 8'h42, exp_cmd: 8'h80};
        vecs[1] = '{idx: 9,  exp_char: 8'h20, exp_cmd: 8'h89};
        vecs[2] = '{idx: 15, exp_char: 8'h31, exp_cmd: 8'h8F};
        vecs[3] = '{idx: 16, exp_char: 8'h20, exp_cmd: 8'hC0};
        vecs[4] = '{idx: 17, exp_char: 8'h53, exp_cmd: 8'hC1};
        vecs[5] = '{idx: 31, exp_char: 8'h23, exp_cmd: 8'hCF};

        // Reset state, with start held during reset
        #10 rst = 1'b1;
        #10;
        check("reset_outputs_zero",
              32'({busy, done, timeout_err, char_valid, char_data, char_idx,
                   lcd_rs, lcd_rw, lcd_en, lcd_data_out, lcd_data_oe}), 32'd0);
        @(negedge clk_1MHz);
        start = 1'b1;
        repeat (2) @(negedge clk_1MHz);
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk_1MHz);
        #1;
        check("start_during_rst_ignored", 32'(busy), 32'd0);

        // Full scan with a second start pulse mid-scan
        run_scan(FIRST_LAT, 1'b1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("char_at_%0d", vecs[i].idx), 32'(got_char[vecs[i].idx]), 32'(vecs[i].exp_char));
            check($sformatf("seta_cmd_%0d", vecs[i].idx), 32'(seta_cmd[vecs[i].idx]), 32'(vecs[i].exp_cmd));
        end
        check("bus_rules", bus_viol, 0);

        // Reset during RD_EN of idx 9
        prime_scan();
        pulse_start();
        found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge clk_1MHz);
            #1;
            if (n_valid == 9 && lcd_en && lcd_rs && lcd_rw)
                found = 1'b1;
        end
        check("reached_rd_en_idx9", 32'(found), 32'd1);
        #200 rst = 1'b1;
        #1;
        check("rst_drops_en", 32'(lcd_en), 32'd0);
        check("rst_outputs_zero",
              32'({busy, done, timeout_err, char_valid, char_data, char_idx,
                   lcd_rs, lcd_rw, lcd_en, lcd_data_out, lcd_data_oe}), 32'd0);
        sb.delete();
        nv = n_valid;
        nd = n_done;
        repeat (3) @(negedge clk_1MHz);
        rst = 1'b0;
        repeat (50) @(negedge clk_1MHz);
        #1;
        check("no_valid_after_rst", n_valid, nv);
        check("no_done_after_rst", n_done, nd);
        run_scan(FIRST_LAT, 1'b0);
        check("rescan_char0", 32'(got_char[0]), 32'h42);

`ifdef LCD_BUSY_POLL_EN
        // Three busy polls before the first char
        bf_polls_left = 3;
        run_scan(11 * (PH + 1), 1'b0);
        check("bf_polls_consumed", bf_polls_left, 0);

        // Stuck busy flag on the BF_TIMEOUT=3 instance
        @(negedge clk_1MHz);
        start_to = 1'b1;
        @(negedge clk_1MHz);
        start_to = 1'b0;
        for (int c = 0; c < 500 && n_done_to == 0; c++)
            @(posedge clk_1MHz);
        repeat (3) @(negedge clk_1MHz);
        #1;
        check("to_done_count", n_done_to, 1);
        check("to_timeout_err", 32'(timeout_err_to), 32'd1);
        check("to_no_valid", n_valid_to, 0);
        check("to_busy_low", 32'(busy_to), 32'd0);
        @(negedge clk_1MHz);
        start_to = 1'b1;
        @(negedge clk_1MHz);
        start_to = 1'b0;
        #1;
        check("to_err_cleared_by_start", 32'(timeout_err_to), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
